// File: rtl/debounce_filter_pkg.sv
// Shared types and default constants for the switch/button debounce filter.
package debounce_filter_pkg;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 1000;
  localparam int DEF_GLITCH_W        = 8;

  // Qualification FSM: two settled levels, each with a "waiting to leave" state.
  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    WAIT_HIGH   = 2'd1,
    STABLE_HIGH = 2'd2,
    WAIT_LOW    = 2'd3
  } db_state_t;

endpackage

// File: rtl/sync_ff_chain.sv
// Multi-flop synchronizer for a single asynchronous bit. The last stage is the
// only output; nothing else in the design may look at the raw input.
module sync_ff_chain #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] chain;

  // Shift the raw bit through DEPTH flops; synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[DEPTH-2:0], d};
    end
  end

  assign q = chain[DEPTH-1];

endmodule

// File: rtl/debounce_filter.sv
// Debounce filter: a synchronized input must hold a new level for
// DEBOUNCE_CYCLES consecutive samples before db_out follows it. Every
// qualification that is abandoned counts as a glitch (saturating counter).
//
// Handshake: none. db_out is a plain registered level; each accepted
// transition produces exactly one edge on it, which downstream edge detectors
// may rely on.
module debounce_filter
  import debounce_filter_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int GLITCH_W        = DEF_GLITCH_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_raw,
  output logic                db_out,
  output logic                settling,
  output logic [GLITCH_W-1:0] glitch_count
);

  localparam int                  CNT_W      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;

  logic                s;
  db_state_t           state;
  db_state_t           state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_nxt;
  logic                db_nxt;
  logic                glitch_inc;
  logic [GLITCH_W-1:0] glitch_nxt;

  sync_ff_chain #(
    .DEPTH (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (in_raw),
    .q     (s)
  );

  // Next-state logic: leave a STABLE state on the first opposite sample,
  // accept after the count completes, fall back (and log a glitch) on reversal.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    db_nxt     = db_out;
    glitch_inc = 1'b0;
    case (state)
      STABLE_LOW: begin
        if (s) begin
          state_nxt = WAIT_HIGH;
          cnt_nxt   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!s) begin
          state_nxt  = STABLE_LOW;
          cnt_nxt    = '0;
          glitch_inc = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_nxt = STABLE_HIGH;
          cnt_nxt   = '0;
          db_nxt    = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      STABLE_HIGH: begin
        if (!s) begin
          state_nxt = WAIT_LOW;
          cnt_nxt   = '0;
        end
      end
      WAIT_LOW: begin
        if (s) begin
          state_nxt  = STABLE_HIGH;
          cnt_nxt    = '0;
          glitch_inc = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_nxt = STABLE_LOW;
          cnt_nxt   = '0;
          db_nxt    = 1'b0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = STABLE_LOW;
        cnt_nxt   = '0;
        db_nxt    = 1'b0;
      end
    endcase
  end

  // Glitch counter sticks at all-ones instead of wrapping.
  always_comb begin
    glitch_nxt = glitch_count;
    if (glitch_inc && (glitch_count != GLITCH_MAX)) begin
      glitch_nxt = glitch_count + GLITCH_W'(1);
    end
  end

  // State register plus registered outputs; settling mirrors the WAIT states.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= STABLE_LOW;
      cnt          <= '0;
      db_out       <= 1'b0;
      settling     <= 1'b0;
      glitch_count <= '0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      db_out       <= db_nxt;
      settling     <= (state_nxt == WAIT_HIGH) || (state_nxt == WAIT_LOW);
      glitch_count <= glitch_nxt;
    end
  end

endmodule

// File: tb/tb_debounce_filter.sv
// Bench for debounce_filter (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, GLITCH_W=4).
// Directed scenarios with fixed expectations, then random bursts checked
// every cycle against a run-length reference model.
module tb_debounce_filter;

  localparam int SYNC = 2;
  localparam int DC   = 4;
  localparam int GW   = 4;

  logic          clk;
  logic          reset;
  logic          in_raw;
  logic          db_out;
  logic          settling;
  logic [GW-1:0] glitch_count;

  int n_checks = 0;
  int n_fail   = 0;

  debounce_filter #(
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DC),
    .GLITCH_W        (GW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_raw       (in_raw),
    .db_out       (db_out),
    .settling     (settling),
    .glitch_count (glitch_count)
  );

  // Clock / reset defaults
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point for every check in the bench.
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Driver tasks: one call = one rising edge; outputs are read 1 ns later.
  task automatic step(input logic v);
    in_raw = v;
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic v, input int n);
    for (int i = 0; i < n; i++) step(v);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    step(in_raw);
    reset = 1'b1;
  endtask

  // Reference model: the synchronizer is a plain delay line of raw samples;
  // the filter is "count consecutive samples that disagree with the accepted
  // level; DC+1 of them flips it, a shorter run that ends is one glitch".
  logic          hq[$];
  logic          s_seen;
  logic          m_db   = 1'b0;
  int            run_len = 0;
  int            m_gl   = 0;
  logic [GW+1:0] exp_q[$];
  logic [GW+1:0] exp_v;

  always @(posedge clk) begin
    if (!reset) begin
      hq = {};
      for (int i = 0; i < SYNC; i++) hq.push_back(1'b0);
      m_db    = 1'b0;
      run_len = 0;
      m_gl    = 0;
    end else begin
      s_seen = hq.pop_front();
      hq.push_back(in_raw);
      if (s_seen != m_db) begin
        run_len++;
        if (run_len == DC + 1) begin
          m_db    = s_seen;
          run_len = 0;
        end
      end else if (run_len > 0) begin
        if (m_gl < (1 << GW) - 1) m_gl++;
        run_len = 0;
      end
    end
    exp_q.push_back({m_db, (run_len > 0), GW'(m_gl)});
  end

  // Scoreboard: compare outputs to the model on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      check_eq("sb_outputs", {26'd0, db_out, settling, glitch_count}, {26'd0, exp_v});
    end
  end

  initial begin
    reset  = 1'b0;
    in_raw = 1'b0;
    step(1'b0);
    step(1'b0);
    check_eq("rst_db", db_out, 0);
    check_eq("rst_settling", settling, 0);
    check_eq("rst_glitch", glitch_count, 0);
    reset = 1'b1;
    hold(1'b0, 3);

    // Clean rise
    for (int e = 1; e <= 7; e++) begin
      step(1'b1);
      if (e == 2) check_eq("rise_settle_e2", settling, 0);
      if (e == 3 || e == 6) check_eq("rise_settle_on", settling, 1);
      if (e == 6) check_eq("rise_db_e6", db_out, 0);
      if (e == 7) begin
        check_eq("rise_db_e7", db_out, 1);
        check_eq("rise_settle_e7", settling, 0);
        check_eq("rise_glitch", glitch_count, 0);
      end
    end
    hold(1'b1, 3);

    // Clean fall
    for (int e = 1; e <= 7; e++) begin
      step(1'b0);
      if (e == 6) check_eq("fall_db_e6", db_out, 1);
      if (e == 7) begin
        check_eq("fall_db_e7", db_out, 0);
        check_eq("fall_glitch", glitch_count, 0);
      end
    end

    // Bounce: 1,1,0 then steady high
    apply_reset();
    hold(1'b0, 3);
    step(1'b1);
    step(1'b1);
    step(1'b0);
    for (int e = 1; e <= 7; e++) begin
      step(1'b1);
      if (e == 2) check_eq("bounce_glitch_early", glitch_count, 1);
      if (e == 6) check_eq("bounce_db_e6", db_out, 0);
      if (e == 7) begin
        check_eq("bounce_db_e7", db_out, 1);
        check_eq("bounce_glitch", glitch_count, 1);
      end
    end

    // Sub-threshold pulse of 3 cycles
    apply_reset();
    hold(1'b0, 3);
    hold(1'b1, 3);
    hold(1'b0, 6);
    check_eq("short_db", db_out, 0);
    check_eq("short_glitch", glitch_count, 1);
    check_eq("short_settle", settling, 0);

    // Glitch counter saturation
    apply_reset();
    hold(1'b0, 3);
    for (int p = 0; p < 20; p++) begin
      hold(1'b1, 2);
      hold(1'b0, 6);
      if (p == 14) check_eq("sat_glitch_15th", glitch_count, 15);
    end
    check_eq("sat_glitch", glitch_count, 15);
    check_eq("sat_db", db_out, 0);

    // Reset in the middle of a qualification
    apply_reset();
    hold(1'b0, 3);
    hold(1'b1, 4);
    check_eq("midrst_settle_before", settling, 1);
    reset = 1'b0;
    step(1'b1);
    check_eq("midrst_db", db_out, 0);
    check_eq("midrst_settle", settling, 0);
    check_eq("midrst_glitch", glitch_count, 0);
    reset = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      step(1'b1);
      if (e == 6) check_eq("midrst_db_e6", db_out, 0);
      if (e == 7) check_eq("midrst_db_e7", db_out, 1);
    end

    // Random bursts of varying length, occasional resets
    for (int b = 0; b < 120; b++) begin
      if ($urandom_range(0, 29) == 0) begin
        apply_reset();
      end else begin
        hold(1'($urandom_range(0, 1)), $urandom_range(1, 8));
      end
    end

    hold(1'b0, 2);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/debounce_filter.md
DEBOUNCE_FILTER -- requirements
Module: debounce_filter

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchronizer flops on in_raw; legal values are 2 or greater.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000, number of consecutive stable synchronized samples required to accept a new level; legal values are 2 or greater.
REQ-003 Parameter GLITCH_W, default 8, width of the glitch counter.
REQ-004 clk  input  1  single clock; all state SHALL change only on its rising edge.
REQ-005 reset  input  1  synchronous, active-low reset; 0 = reset.
REQ-006 in_raw  input  1  asynchronous, bouncy raw input (switch or button).
REQ-007 db_out  output  1  debounced, synchronous level; this feeds the downstream one-pulse edge detector.
REQ-008 settling  output  1  high while a candidate level change is being qualified.
REQ-009 glitch_count  output  GLITCH_W  count of rejected (unqualified) transitions.

Function
REQ-010 in_raw SHALL pass through a SYNC_STAGES-deep flop chain; its last stage is the synchronized sample s; no other logic SHALL observe in_raw.
REQ-011 The FSM SHALL have four states: STABLE_LOW, WAIT_HIGH, STABLE_HIGH and WAIT_LOW.
REQ-012 STABLE_LOW with s=1: go to WAIT_HIGH and clear cnt to 0; with s=0: stay.
REQ-013 WAIT_HIGH with s=1 and cnt<DEBOUNCE_CYCLES-1: increment cnt.
REQ-014 WAIT_HIGH with s=1 and cnt=DEBOUNCE_CYCLES-1: go to STABLE_HIGH and set db_out to 1.
REQ-015 WAIT_HIGH with s=0: return to STABLE_LOW, keep db_out at 0, and increment glitch_count.
REQ-016 STABLE_HIGH, WAIT_LOW and the return to STABLE_HIGH SHALL mirror REQ-012 to REQ-015 with the polarities inverted.
REQ-017 db_out SHALL be a registered output that changes only on the STABLE_* entries of REQ-014 and REQ-016; it SHALL never glitch.
REQ-018 Latency: take the edge that first samples in_raw at a new level as edge 1; if in_raw holds that level, db_out SHALL take it after edge SYNC_STAGES+DEBOUNCE_CYCLES+1.
REQ-019 Any reversal of s during WAIT_* SHALL restart qualification from zero, with no partial credit.
REQ-020 cnt width SHALL be $clog2(DEBOUNCE_CYCLES); cnt SHALL never exceed DEBOUNCE_CYCLES-1.
REQ-021 glitch_count SHALL saturate at all-ones and SHALL not wrap.
REQ-022 settling SHALL be a registered output, equal to 1 exactly when the state is WAIT_HIGH or WAIT_LOW.
REQ-023 db_out SHALL not change on any cycle in which a level is not fully qualified, so downstream logic sees at most one edge per accepted transition.

Reset
REQ-024 When reset=0 at a rising clk edge, the following SHALL apply on that edge: sync chain all 0, state STABLE_LOW, cnt 0, db_out 0, settling 0, glitch_count 0.
REQ-025 Reset asserted mid-qualification SHALL discard the qualification; no db_out edge and no glitch increment SHALL result.
REQ-026 If in_raw is high when reset is released, it SHALL be qualified as a normal rising transition under REQ-018.

Structure
REQ-027 A shared package SHALL hold the FSM state enum (2-bit) and the default parameter constants.
REQ-028 One sub-module, sync_ff_chain, parameterized by depth, SHALL implement REQ-010; the FSM, counter and glitch logic SHALL live in debounce_filter.

Verification (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, GLITCH_W=4)
REQ-029 Clean rise: in_raw goes 0 to 1 and holds -> db_out=1 after edge 7; settling=1 during edges 3 to 6; glitch_count=0.
REQ-030 Bounce: in_raw high for 2 cycles, low for 1, then high steadily -> exactly one db_out rise, 7 edges after the final rising sample; glitch_count=1.
REQ-031 Clean fall from STABLE_HIGH: in_raw goes 1 to 0 and holds -> db_out=0 after edge 7; glitch_count unchanged.
REQ-032 Saturation: 20 pulses, each 2 cycles high then 6 low -> db_out stays 0; glitch_count=15 (saturated, not wrapped).
REQ-033 Reset mid-qualification: reset=0 for 1 cycle while in WAIT_HIGH, in_raw held high -> all outputs 0 on that edge; db_out rises 7 edges after reset release.
REQ-034 Sub-threshold pulse: in_raw high for exactly 3 cycles -> db_out stays 0; glitch_count=1; settling returns to 0.
